// File: rtl/tempsense_pkg.sv
// ---------------------------------------------------------------------------
// tempsense_pkg
// Shared definitions for the temperature-sensor PWM decoder:
//   - decoder state encoding (2-bit enum)
//   - default counter width and averaging depth
//   - helper returning the all-ones saturation value for a given width
// ---------------------------------------------------------------------------
package tempsense_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ACCUM = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam int CNT_W_DEF    = 12;
  localparam int AVG_LOG2_DEF = 2;

  // Largest value representable in 'width' bits (valid for width <= 31).
  function automatic logic [31:0] sat_value(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/tempsense_sync.sv
// ---------------------------------------------------------------------------
// tempsense_sync
// Multi-flop synchroniser bringing one asynchronous bit into the clk domain.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (chain clears to 0)
//   i_d      asynchronous input bit
//   o_q      synchronised output (STAGES cycles of latency)
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module tempsense_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/tempsense_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tempsense_pwm_decoder
// Measures the PWM high time inside each sensor measurement window, averages
// 2^AVG_LOG2 windows and presents the result on a valid/ready handshake.
// Ports:
//   clk        system clock (much faster than the sensor clock)
//   reset_n    asynchronous active-low reset
//   i_pwm      asynchronous PWM from the sensor
//   i_window   asynchronous measurement-window strobe
//   i_clear    synchronous clear of batch, flags and pending output
//   i_ready    downstream ready
//   o_code     averaged high-time code in clk cycles
//   o_valid    o_code valid
//   o_sat      some window of this batch saturated (qualified by o_valid)
//   o_overrun  sticky: a window was skipped while an output was pending
//   o_busy     a batch is in progress
// ---------------------------------------------------------------------------
module tempsense_pwm_decoder
  import tempsense_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int AVG_LOG2    = AVG_LOG2_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_pwm,
  input  logic             i_window,
  input  logic             i_clear,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_code,
  output logic             o_valid,
  output logic             o_sat,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int ACC_W   = CNT_W + AVG_LOG2;
  localparam int NWIN_W  = AVG_LOG2 + 1;
  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  SAT      = CNT_W'(sat_value(CNT_W));
  localparam logic [NWIN_W-1:0] LAST_WIN = NWIN_W'((1 << AVG_LOG2) - 1);

  logic               w_pwm;
  logic               w_win;
  logic               r_win_d;
  logic [PRIME_W-1:0] r_prime;
  logic               w_primed;
  logic               w_rise;
  logic               w_fall;
  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [NWIN_W-1:0]  r_nwin;
  logic               r_batch_sat;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   w_shift;
  logic               w_last;

  tempsense_sync #(.STAGES(SYNC_STAGES)) u_sync_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (i_pwm),
    .o_q     (w_pwm)
  );

  tempsense_sync #(.STAGES(SYNC_STAGES)) u_sync_win (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (i_window),
    .o_q     (w_win)
  );

  // The synchronisers hold 0 until the pin value has propagated through them.
  // Until then the history flop is pinned high, so a window that was already
  // open across reset never looks like a fresh rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prime <= '0;
      r_win_d <= 1'b1;
    end else if (!w_primed) begin
      r_prime <= r_prime + PRIME_W'(1);
      r_win_d <= 1'b1;
    end else begin
      r_win_d <= w_win;
    end
  end

  assign w_primed = (r_prime == PRIME_W'(SYNC_STAGES));
  assign w_rise   = w_primed &  w_win & ~r_win_d;
  assign w_fall   = w_primed & ~w_win &  r_win_d;

  assign w_sum   = r_acc + ACC_W'(r_cnt);
  assign w_shift = w_sum >> AVG_LOG2;
  assign w_last  = (r_nwin == LAST_WIN);
  assign o_busy  = (r_state != S_IDLE) || (r_nwin != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // In OUT a window rise only flags an overrun; the state leaves OUT solely
  // on a completed transfer, so the skipped window is already open by then.
  always_comb begin
    w_next = r_state;
    if (i_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_rise) w_next = S_COUNT;
        S_COUNT: if (w_fall) w_next = S_ACCUM;
        S_ACCUM: w_next = w_last ? S_OUT : S_IDLE;
        S_OUT:   if (i_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_nwin      <= '0;
      r_batch_sat <= 1'b0;
      o_code      <= '0;
      o_valid     <= 1'b0;
      o_sat       <= 1'b0;
      o_overrun   <= 1'b0;
    end else if (i_clear) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_nwin      <= '0;
      r_batch_sat <= 1'b0;
      o_valid     <= 1'b0;
      o_sat       <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) r_cnt <= '0;
        end
        S_COUNT: begin
          // Counter sticks at all-ones; reaching it marks the batch saturated.
          if (w_win && w_pwm) begin
            if (r_cnt != SAT) r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt >= SAT - CNT_W'(1)) r_batch_sat <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_last) begin
            o_code      <= w_shift[CNT_W-1:0];
            o_sat       <= r_batch_sat;
            o_valid     <= 1'b1;
            r_acc       <= '0;
            r_nwin      <= '0;
            r_batch_sat <= 1'b0;
          end else begin
            r_acc  <= w_sum;
            r_nwin <= r_nwin + NWIN_W'(1);
          end
        end
        S_OUT: begin
          if (i_ready) o_valid   <= 1'b0;
          if (w_rise)  o_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tempsense_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_tempsense_pwm_decoder
// Drives whole measurement windows with chosen PWM high times and compares
// the decoder's outputs against the arithmetic average of those high times.
// ---------------------------------------------------------------------------
module tb_tempsense_pwm_decoder;

  localparam int CNT_W       = 12;
  localparam int AVG_LOG2    = 2;
  localparam int SYNC_STAGES = 2;
  localparam int MAXC        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             i_pwm = 1'b0;
  logic             i_window = 1'b0;
  logic             i_clear = 1'b0;
  logic             i_ready = 1'b0;
  logic [CNT_W-1:0] o_code;
  logic             o_valid;
  logic             o_sat;
  logic             o_overrun;
  logic             o_busy;

  int n_cmp = 0;
  int n_err = 0;
  int q_code[$];
  bit q_sat[$];

  always #5 clk = ~clk;

  tempsense_pwm_decoder #(
    .CNT_W       (CNT_W),
    .AVG_LOG2    (AVG_LOG2),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_pwm     (i_pwm),
    .i_window  (i_window),
    .i_clear   (i_clear),
    .i_ready   (i_ready),
    .o_code    (o_code),
    .o_valid   (o_valid),
    .o_sat     (o_sat),
    .o_overrun (o_overrun),
    .o_busy    (o_busy)
  );

  // Record every completed transfer seen on the output handshake.
  always @(negedge clk) begin
    if (reset_n && o_valid && i_ready) begin
      q_code.push_back(int'(o_code));
      q_sat.push_back(o_sat);
    end
  end

  // Reference: a window's count is its PWM high time, capped at the counter
  // maximum; the code is the floor of the mean of four such counts.
  function automatic int clip(input int h);
    return (h > MAXC) ? MAXC : h;
  endfunction

  function automatic int model_code(input int h0, input int h1, input int h2, input int h3);
    return (clip(h0) + clip(h1) + clip(h2) + clip(h3)) / 4;
  endfunction

  function automatic bit model_sat(input int h0, input int h1, input int h2, input int h3);
    return (h0 >= MAXC) || (h1 >= MAXC) || (h2 >= MAXC) || (h3 >= MAXC);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One window of (hl + 10) cycles with PWM high for hl cycles inside it,
  // followed by 20 idle cycles.
  task automatic send_window(input int hl);
    int len;
    len = hl + 10;
    for (int i = 0; i < len; i++) begin
      tick();
      i_window = 1'b1;
      i_pwm    = (i >= 5) && (i < 5 + hl);
    end
    tick();
    i_window = 1'b0;
    i_pwm    = 1'b0;
    repeat (19) tick();
  endtask

  task automatic send_batch(input int h0, input int h1, input int h2, input int h3);
    send_window(h0);
    send_window(h1);
    send_window(h2);
    send_window(h3);
  endtask

  task automatic wait_xfer(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (q_code.size() > 0) break;
      @(negedge clk);
    end
    ok = (q_code.size() > 0);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) break;
    end
    ok = (o_valid === 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (o_code !== '0)      begin n_err++; $display("[TB] FAIL reset_code: got %0d expected 0", o_code); end
    n_cmp++; if (o_valid !== 1'b0)   begin n_err++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_sat !== 1'b0)     begin n_err++; $display("[TB] FAIL reset_sat: got %b expected 0", o_sat); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("[TB] FAIL reset_overrun: got %b expected 0", o_overrun); end
    n_cmp++; if (o_busy !== 1'b0)    begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
  endtask

  // Expects exactly one transfer carrying (exp_code, exp_sat).
  task automatic check_batch_result(input string name, input int exp_code, input bit exp_sat);
    bit ok;
    wait_xfer(60, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("[TB] FAIL %s_timeout: got no transfer expected one", name);
    end else begin
      n_cmp++; if (q_code[0] != exp_code) begin n_err++; $display("[TB] FAIL %s_code: got %0d expected %0d", name, q_code[0], exp_code); end
      n_cmp++; if (q_sat[0] != exp_sat)   begin n_err++; $display("[TB] FAIL %s_sat: got %0d expected %0d", name, q_sat[0], exp_sat); end
      n_cmp++; if (q_code.size() != 1)    begin n_err++; $display("[TB] FAIL %s_count: got %0d expected 1", name, q_code.size()); end
    end
    q_code.delete();
    q_sat.delete();
  endtask

  task automatic test_uniform();
    i_ready = 1'b1;
    q_code.delete(); q_sat.delete();
    send_batch(40, 40, 40, 40);
    check_batch_result("uniform", model_code(40, 40, 40, 40), 1'b0);
    repeat (4) tick();
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL uniform_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_mixed();
    send_batch(10, 20, 30, 41);
    check_batch_result("mixed", model_code(10, 20, 30, 41), 1'b0);
  endtask

  task automatic test_back_to_back();
    int h[4];
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) h[k] = int'($urandom_range(0, 200));
      send_batch(h[0], h[1], h[2], h[3]);
      check_batch_result("random", model_code(h[0], h[1], h[2], h[3]), 1'b0);
    end
  endtask

  task automatic test_saturation();
    send_batch(4200, 100, 200, 300);
    check_batch_result("sat", model_code(4200, 100, 200, 300), model_sat(4200, 100, 200, 300));
    send_batch(10, 10, 10, 12);
    check_batch_result("sat_cleared", model_code(10, 10, 10, 12), 1'b0);
  endtask

  task automatic test_overrun();
    int h[4];
    int e;
    bit ok;
    for (int k = 0; k < 4; k++) h[k] = int'($urandom_range(0, 150));
    e = model_code(h[0], h[1], h[2], h[3]);
    i_ready = 1'b0;
    q_code.delete(); q_sat.delete();
    send_batch(h[0], h[1], h[2], h[3]);
    wait_valid(40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("[TB] FAIL ovr_valid: got %b expected 1", o_valid); end
    send_window(70);
    send_window(33);
    @(negedge clk);
    n_cmp++; if (o_code !== CNT_W'(e)) begin n_err++; $display("[TB] FAIL ovr_hold_code: got %0d expected %0d", o_code, e); end
    n_cmp++; if (o_valid !== 1'b1)     begin n_err++; $display("[TB] FAIL ovr_hold_valid: got %b expected 1", o_valid); end
    n_cmp++; if (o_overrun !== 1'b1)   begin n_err++; $display("[TB] FAIL ovr_flag: got %b expected 1", o_overrun); end
    tick();
    i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("[TB] FAIL ovr_drop: got %b expected 0", o_valid); end
    check_batch_result("ovr_xfer", e, 1'b0);
    send_window(12);
    send_window(24);
    send_window(36);
    n_cmp++; if (q_code.size() != 0) begin n_err++; $display("[TB] FAIL ovr_early: got %0d transfers expected 0", q_code.size()); end
    send_window(48);
    check_batch_result("ovr_next", model_code(12, 24, 36, 48), 1'b0);
  endtask

  task automatic test_clear();
    bit ok;
    i_ready = 1'b0;
    send_batch(50, 60, 70, 80);
    wait_valid(40, ok);
    n_cmp++; if (o_code !== CNT_W'(model_code(50, 60, 70, 80))) begin n_err++; $display("[TB] FAIL clr_pending: got %0d expected %0d", o_code, model_code(50, 60, 70, 80)); end
    send_window(15);
    tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0)   begin n_err++; $display("[TB] FAIL clr_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("[TB] FAIL clr_overrun: got %b expected 0", o_overrun); end
    n_cmp++; if (o_busy !== 1'b0)    begin n_err++; $display("[TB] FAIL clr_busy: got %b expected 0", o_busy); end
    i_ready = 1'b1;
    q_code.delete(); q_sat.delete();
    send_batch(0, 30, 50, 20);
    check_batch_result("clr_zero", model_code(0, 30, 50, 20), 1'b0);
  endtask

  task automatic test_async_reset();
    i_ready = 1'b1;
    q_code.delete(); q_sat.delete();
    send_window(60);
    send_window(70);
    for (int i = 0; i < 26; i++) begin
      tick();
      i_window = 1'b1;
      i_pwm    = (i >= 5);
    end
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("[TB] FAIL arst_busy_before: got %b expected 1", o_busy); end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0)    begin n_err++; $display("[TB] FAIL arst_busy: got %b expected 0", o_busy); end
    n_cmp++; if (o_code !== '0)      begin n_err++; $display("[TB] FAIL arst_code: got %0d expected 0", o_code); end
    n_cmp++; if (o_valid !== 1'b0)   begin n_err++; $display("[TB] FAIL arst_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("[TB] FAIL arst_overrun: got %b expected 0", o_overrun); end
    tick();
    tick();
    reset_n = 1'b1;
    repeat (30) tick();
    i_window = 1'b0;
    i_pwm    = 1'b0;
    repeat (20) tick();
    send_window(11);
    send_window(22);
    send_window(33);
    n_cmp++; if (q_code.size() != 0) begin n_err++; $display("[TB] FAIL arst_early: got %0d transfers expected 0", q_code.size()); end
    send_window(44);
    check_batch_result("arst_next", model_code(11, 22, 33, 44), 1'b0);
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_mixed();
    test_back_to_back();
    test_saturation();
    test_overrun();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
